fano_enc_ctrl: RTL and testbench

Sequencing controller in front of the Fano convolutional encoder. It accepts 89-bit data words from upstream over a valid/ready handshake and issues them to the encoder one per cycle. It tracks words in flight through the encoder pipeline and serialises code-rate and differential-mode changes by stalling, draining, pulsing the encoder reset with the new rate held stable, then resuming. It sits between the frame builder and the encoder.

---
 rtl/fano_enc_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fano_enc_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fano_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fano_enc_ctrl
// Brief    : Sequencing controller ahead of the Fano convolutional encoder:
//            word issue, in-flight tracking, drain/reset/resume on reconfig.
//            Optional drain watchdog enabled by FANO_CTRL_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fano_enc_ctrl #(
    parameter int DATA_W     = 89,
    parameter int LATENCY    = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_vld,
    output logic              s_rdy,
    input  logic [DATA_W-1:0] s_data,
    input  logic              cfg_req,
    input  logic [1:0]        cfg_code_rate,
    input  logic              cfg_diff_en,
    output logic              cfg_rdy,
    output logic              cfg_done,
    output logic              enc_reset_n,
    output logic [1:0]        enc_code_rate,
    output logic              enc_diff_en,
    output logic              enc_vld,
    output logic [DATA_W-1:0] enc_data,
    input  logic              enc_o_vld,
    output logic              o_busy,
    output logic              o_err
);

    localparam int c_IF_W = $clog2(LATENCY + 2);
    localparam int c_RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RC_W-1:0] c_RST_LAST = c_RC_W'(RST_CYCLES - 1);

    localparam logic [1:0] c_ST_RST    = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_RUN    = 2'd2;
    localparam logic [1:0] c_ST_DRAIN  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_RC_W-1:0] r_rst_cnt;
    logic [c_IF_W-1:0] r_inflight;
    logic [1:0]        r_pend_rate;
    logic              r_pend_diff;
    logic [1:0]        w_pend_rate_nxt;
    logic              w_pend_diff_nxt;

    logic              r_s_rdy;
    logic              r_cfg_rdy;
    logic              r_cfg_done;
    logic              r_enc_reset_n;
    logic [1:0]        r_enc_code_rate;
    logic              r_enc_diff_en;
    logic              r_enc_vld;
    logic [DATA_W-1:0] r_enc_data;
    logic              r_busy;
    logic              r_err;

    logic w_accept;
    logic w_cfg_acc;
    logic w_dec;
    logic w_drained;
    logic w_wdog_fire;
    logic w_err_set;

    assign w_accept  = s_vld & r_s_rdy;
    assign w_cfg_acc = cfg_req & r_cfg_rdy;
    assign w_dec     = enc_o_vld && (r_inflight != '0);
    assign w_drained = (r_inflight == '0) && !r_enc_vld;

    // Rate 3 is illegal: it is still accepted but falls back to rate 1/2
    assign w_pend_rate_nxt = w_cfg_acc ? ((cfg_code_rate == 2'd3) ? 2'd0 : cfg_code_rate)
                                       : r_pend_rate;
    assign w_pend_diff_nxt = w_cfg_acc ? cfg_diff_en : r_pend_diff;

    assign w_err_set = (cfg_req && !r_cfg_rdy)
                    || (w_cfg_acc && (cfg_code_rate == 2'd3))
                    || (enc_o_vld && (r_inflight == '0))
                    || w_wdog_fire;

`ifdef FANO_CTRL_WDOG_EN
    localparam int c_WD_W = $clog2(LATENCY + 4);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(LATENCY + 3);

    logic [c_WD_W-1:0] r_wd_cnt;

    always_ff @(posedge clk) begin
        if (reset || (r_state != c_ST_DRAIN)) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != c_WD_LAST) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wdog_fire = (r_state == c_ST_DRAIN) && !w_drained && (r_wd_cnt == c_WD_LAST);
`else
    assign w_wdog_fire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RST:    if (r_rst_cnt == c_RST_LAST) w_state_nxt = c_ST_SETTLE;
            c_ST_SETTLE: w_state_nxt = c_ST_RUN;
            c_ST_RUN:    if (cfg_req) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN:  if (w_drained || w_wdog_fire) w_state_nxt = c_ST_RST;
            default:     w_state_nxt = c_ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_RST;
            r_rst_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_ST_RST) && (r_rst_cnt != c_RST_LAST)) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end else begin
                r_rst_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_wdog_fire) begin
            r_inflight <= '0;
        end else begin
            case ({r_enc_vld, w_dec})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Control outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_rate     <= 2'd0;
            r_pend_diff     <= 1'b0;
            r_s_rdy         <= 1'b0;
            r_cfg_rdy       <= 1'b0;
            r_cfg_done      <= 1'b0;
            r_enc_reset_n   <= 1'b0;
            r_enc_code_rate <= 2'd0;
            r_enc_diff_en   <= 1'b0;
            r_enc_vld       <= 1'b0;
            r_enc_data      <= '0;
            r_busy          <= 1'b1;
            r_err           <= 1'b0;
        end else begin
            r_pend_rate   <= w_pend_rate_nxt;
            r_pend_diff   <= w_pend_diff_nxt;
            r_s_rdy       <= (w_state_nxt == c_ST_RUN);
            r_cfg_rdy     <= (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_DRAIN);
            r_cfg_done    <= (r_state == c_ST_SETTLE);
            r_enc_reset_n <= (w_state_nxt != c_ST_RST);
            r_busy        <= (w_state_nxt != c_ST_RUN);
            r_enc_vld     <= w_accept;
            if (w_state_nxt == c_ST_RST) begin
                r_enc_code_rate <= w_pend_rate_nxt;
                r_enc_diff_en   <= w_pend_diff_nxt;
            end
            if (w_accept) begin
                r_enc_data <= s_data;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_rdy         = r_s_rdy;
    assign cfg_rdy       = r_cfg_rdy;
    assign cfg_done      = r_cfg_done;
    assign enc_reset_n   = r_enc_reset_n;
    assign enc_code_rate = r_enc_code_rate;
    assign enc_diff_en   = r_enc_diff_en;
    assign enc_vld       = r_enc_vld;
    assign enc_data      = r_enc_data;
    assign o_busy        = r_busy;
    assign o_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fano_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fano_enc_ctrl
// Brief    : Self-checking bench for fano_enc_ctrl with a behavioural model,
//            a modelled encoder pipeline and directed plus random phases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fano_enc_ctrl;

    localparam int DATA_W = 89;
    localparam int LAT    = 8;
    localparam int RC     = 2;
`ifdef FANO_CTRL_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              s_vld;
    logic              s_rdy;
    logic [DATA_W-1:0] s_data;
    logic              cfg_req;
    logic [1:0]        cfg_code_rate;
    logic              cfg_diff_en;
    logic              cfg_rdy;
    logic              cfg_done;
    logic              enc_reset_n;
    logic [1:0]        enc_code_rate;
    logic              enc_diff_en;
    logic              enc_vld;
    logic [DATA_W-1:0] enc_data;
    logic              enc_o_vld;
    logic              o_busy;
    logic              o_err;

    fano_enc_ctrl #(.DATA_W(DATA_W), .LATENCY(LAT), .RST_CYCLES(RC)) dut (
        .clk(clk), .reset(reset),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data),
        .cfg_req(cfg_req), .cfg_code_rate(cfg_code_rate), .cfg_diff_en(cfg_diff_en),
        .cfg_rdy(cfg_rdy), .cfg_done(cfg_done),
        .enc_reset_n(enc_reset_n), .enc_code_rate(enc_code_rate), .enc_diff_en(enc_diff_en),
        .enc_vld(enc_vld), .enc_data(enc_data), .enc_o_vld(enc_o_vld),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The controller is described by what it is doing right now: holding the
    // encoder in reset (cycles left), settling, streaming, or draining.
    int                m_rst_left   = RC;
    bit                m_settling   = 1'b0;
    bit                m_streaming  = 1'b0;
    bit                m_draining   = 1'b0;
    int                m_drain_cyc  = 0;
    logic [1:0]        m_pend_rate  = 2'd0;
    logic              m_pend_diff  = 1'b0;
    logic              e_cfg_done   = 1'b0;
    logic [1:0]        e_rate       = 2'd0;
    logic              e_diff       = 1'b0;
    logic              e_enc_vld    = 1'b0;
    logic [DATA_W-1:0] e_enc_data   = '0;
    logic              e_err        = 1'b0;
    logic [3:0]        e_inflight   = 4'd0;

    always @(posedge clk) begin
        bit acc, cfg_ok, dec, old_vld;
        logic [3:0] old_if;
        if (reset) begin
            m_rst_left  = RC;
            m_settling  = 1'b0;
            m_streaming = 1'b0;
            m_draining  = 1'b0;
            m_drain_cyc = 0;
            m_pend_rate = 2'd0;
            m_pend_diff = 1'b0;
            e_cfg_done  = 1'b0;
            e_rate      = 2'd0;
            e_diff      = 1'b0;
            e_enc_vld   = 1'b0;
            e_enc_data  = '0;
            e_err       = 1'b0;
            e_inflight  = 4'd0;
        end else begin
            acc    = s_vld && m_streaming;
            cfg_ok = cfg_req && (m_streaming || m_draining);
            if (cfg_req && !cfg_ok) e_err = 1'b1;
            if (cfg_ok) begin
                if (cfg_code_rate == 2'd3) begin
                    e_err = 1'b1;
                    m_pend_rate = 2'd0;
                end else begin
                    m_pend_rate = cfg_code_rate;
                end
                m_pend_diff = cfg_diff_en;
            end
            old_if  = e_inflight;
            old_vld = e_enc_vld;
            dec     = enc_o_vld && (old_if != 0);
            if (enc_o_vld && old_if == 0) e_err = 1'b1;
            e_inflight = old_if + {3'd0, old_vld} - {3'd0, dec};
            e_cfg_done = 1'b0;
            if (m_rst_left > 0) begin
                m_rst_left--;
                if (m_rst_left == 0) m_settling = 1'b1;
            end else if (m_settling) begin
                m_settling  = 1'b0;
                m_streaming = 1'b1;
                e_cfg_done  = 1'b1;
            end else if (m_streaming) begin
                if (cfg_ok) begin
                    m_streaming = 1'b0;
                    m_draining  = 1'b1;
                    m_drain_cyc = 0;
                end
            end else if (m_draining) begin
                m_drain_cyc++;
                if (old_if == 0 && !old_vld) begin
                    m_draining = 1'b0;
                    m_rst_left = RC;
                    e_rate = m_pend_rate;
                    e_diff = m_pend_diff;
                end else if (WDOG && m_drain_cyc == LAT + 4) begin
                    m_draining = 1'b0;
                    m_rst_left = RC;
                    e_rate = m_pend_rate;
                    e_diff = m_pend_diff;
                    e_inflight = 4'd0;
                    e_err = 1'b1;
                end
            end
            e_enc_vld = acc;
            if (acc) e_enc_data = s_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctrl{s_rdy,cfg_rdy,cfg_done,rst_n,rate,diff,vld,busy,err,inflight}",
                {s_rdy, cfg_rdy, cfg_done, enc_reset_n, enc_code_rate, enc_diff_en,
                 enc_vld, o_busy, o_err, dut.r_inflight},
                {m_streaming, m_streaming | m_draining, e_cfg_done, (m_rst_left == 0),
                 e_rate, e_diff, e_enc_vld, !m_streaming, e_err, e_inflight});
            chk("enc_data", enc_data, e_enc_data);
        end
    end

    // ---------------- stimulus and encoder model ----------------
    logic enc_q[$];
    bit   drop_resp = 1'b0;
    bit   spur      = 1'b0;

    function automatic logic [DATA_W-1:0] rnd();
        logic [95:0] v;
        v = {$urandom, $urandom, $urandom};
        return v[DATA_W-1:0];
    endfunction

    task automatic step();
        logic v;
        @(posedge clk);
        #1;
        enc_q.push_back(enc_vld);
        v = enc_q.pop_front();
        if (v && drop_resp) begin
            v = 1'b0;
            drop_resp = 1'b0;
        end
        enc_o_vld = v | spur;
        spur    = 1'b0;
        s_vld   = 1'b0;
        cfg_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        enc_q = {};
        repeat (LAT) enc_q.push_back(1'b0);
        enc_o_vld = 1'b0;
        reset = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!s_rdy && n < 10) begin
            step();
            n++;
        end
        chk("wait_run", s_rdy, 1'b1);
    endtask

    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] w;
    int peak, low, first_low, last_ov, bad, done_cnt, early;

    initial begin
        reset = 1'b1; s_vld = 1'b0; s_data = '0; cfg_req = 1'b0;
        cfg_code_rate = 2'd0; cfg_diff_en = 1'b0; enc_o_vld = 1'b0;
        repeat (LAT) enc_q.push_back(1'b0);

        // Reset state and release timing
        step();
        chk_en = 1'b1;
        step();
        chk("reset_outputs", {s_rdy, cfg_rdy, cfg_done, enc_reset_n, enc_code_rate,
                              enc_diff_en, enc_vld, o_busy, o_err}, 10'b0000000010);
        chk("reset_data", enc_data, '0);
        chk("reset_inflight", dut.r_inflight, 4'd0);
        reset = 1'b0;
        step();
        chk("release_c1", {enc_reset_n, s_rdy}, 2'b00);
        step();
        chk("release_c2", {enc_reset_n, s_rdy, cfg_done}, 3'b100);
        step();
        chk("release_c3", {s_rdy, cfg_done, enc_code_rate}, 4'b1100);

        // 20 back-to-back words
        peak = 0;
        for (int i = 0; i < 34; i++) begin
            if (i < 20) begin
                s_vld = 1'b1;
                s_data = rnd();
                sb.push_back(s_data);
            end
            step();
            if (enc_vld) begin
                if (sb.size() == 0) chk("stream_extra_word", 1'b1, 1'b0);
                else chk("stream_order", enc_data, sb.pop_front());
            end
            if (int'(dut.r_inflight) > peak) peak = int'(dut.r_inflight);
        end
        chk("stream_peak", peak, 8);
        chk("stream_all_issued", sb.size(), 0);
        chk("stream_end", {dut.r_inflight, o_err}, 5'b00000);

        // Reconfigure mid-stream with a word in the same cycle
        for (int i = 0; i < 6; i++) begin
            s_vld = 1'b1;
            s_data = rnd();
            if (i == 5) begin
                cfg_req = 1'b1; cfg_code_rate = 2'd1; cfg_diff_en = 1'b1;
                w = s_data;
            end
            step();
        end
        chk("cfg_word_issued", {enc_vld, enc_data}, {1'b1, w});
        chk("cfg_s_rdy_fell", s_rdy, 1'b0);
        low = 0; first_low = 0; last_ov = 0; bad = 0; early = 0; done_cnt = 0;
        for (int c = 1; c <= 60 && done_cnt == 0; c++) begin
            step();
            if (enc_o_vld) last_ov = c;
            if (!enc_reset_n) begin
                low++;
                if (first_low == 0) first_low = c;
                if (enc_code_rate != 2'd1 || !enc_diff_en) bad++;
            end
            if (s_rdy && !cfg_done) early++;
            if (cfg_done) done_cnt++;
        end
        chk("cfg_done_seen", done_cnt, 1);
        chk("cfg_reset_cycles", low, RC);
        chk("cfg_rate_stable", bad, 0);
        chk("cfg_reset_after_drain", first_low > last_ov, 1'b1);
        chk("cfg_s_rdy_held_low", early, 0);
        chk("cfg_resume", {s_rdy, enc_code_rate, enc_diff_en}, 4'b1011);

        // Two requests while draining: last one wins, single cfg_done
        for (int i = 0; i < 4; i++) begin
            s_vld = 1'b1;
            s_data = rnd();
            step();
        end
        cfg_req = 1'b1; cfg_code_rate = 2'd1; cfg_diff_en = 1'b0;
        step();
        step();
        chk("drain_handshake", {s_rdy, cfg_rdy}, 2'b01);
        cfg_req = 1'b1; cfg_code_rate = 2'd2; cfg_diff_en = 1'b0;
        low = 0; bad = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (!enc_reset_n) begin
                low++;
                if (enc_code_rate != 2'd2) bad++;
            end
            if (cfg_done) done_cnt++;
        end
        chk("double_cfg_done_count", done_cnt, 1);
        chk("double_cfg_rate", {bad[3:0], enc_code_rate}, 6'b000010);
        chk("double_cfg_low", low, RC);
        chk("double_cfg_no_err", o_err, 1'b0);

        // Illegal rate 3 falls back to rate 0
        cfg_req = 1'b1; cfg_code_rate = 2'd3; cfg_diff_en = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 20 && done_cnt == 0; c++) begin
            step();
            if (cfg_done) done_cnt++;
        end
        chk("rate3_done", done_cnt, 1);
        chk("rate3_rate_err", {enc_code_rate, o_err}, 3'b001);

        // Request during RST is dropped and flagged
        do_reset(2);
        cfg_req = 1'b1; cfg_code_rate = 2'd1; cfg_diff_en = 1'b1;
        step();
        chk("rst_cfg_dropped", {cfg_rdy, o_err}, 2'b01);
        wait_run();
        step(); step(); step();
        chk("rst_cfg_no_drain", {s_rdy, enc_code_rate, enc_diff_en}, 4'b1000);

        // Spurious encoder output with nothing in flight
        do_reset(2);
        wait_run();
        chk("pre_spur_err", o_err, 1'b0);
        spur = 1'b1;
        step();
        step();
        chk("spur_err", {o_err, dut.r_inflight}, 5'b10000);

        // Lost encoder response during a drain
        do_reset(2);
        wait_run();
        s_vld = 1'b1; s_data = rnd();
        cfg_req = 1'b1; cfg_code_rate = 2'd2; cfg_diff_en = 1'b0;
        drop_resp = 1'b1;
        step();
        chk("wdog_drain_entry", {s_rdy, cfg_rdy, enc_reset_n}, 3'b011);
        if (WDOG) begin
            low = 0;
            for (int c = 1; c < LAT + 4; c++) begin
                step();
                if (!enc_reset_n) low++;
            end
            chk("wdog_no_early_rst", low, 0);
            step();
            chk("wdog_rst_entered", {enc_reset_n, o_err, enc_code_rate}, 4'b0110);
        end else begin
            repeat (40) step();
            chk("no_wdog_stuck", {s_rdy, cfg_rdy, enc_reset_n, o_busy, o_err}, 5'b01110);
        end

        // Random traffic against the model
        do_reset(2);
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 999) < 4) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                s_vld  = 1'($urandom_range(0, 1));
                s_data = rnd();
                if ($urandom_range(0, 29) == 0) begin
                    cfg_req       = 1'b1;
                    cfg_code_rate = 2'($urandom_range(0, 3));
                    cfg_diff_en   = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 199) == 0) spur = 1'b1;
                step();
            end
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
